// File: rtl/sig_deser_if.sv
// Capture-side bus of sig_deser: sampled input controls and the packed-word outputs.
// master = deserializer side, slave = driver/consumer side.
interface sig_deser_if #(
    parameter int unsigned WCNT_W = 16
);
    logic              sig;
    logic              hold;
    logic [31:0]       dsq;
    logic              pclk;
    logic              wvalid;
    logic [WCNT_W-1:0] wcnt;

    modport master (input sig, hold, output dsq, pclk, wvalid, wcnt);
    modport slave  (output sig, hold, input dsq, pclk, wvalid, wcnt);
endinterface

// File: rtl/sig_deser.sv
// Samples an async input (optionally prescaled), packs 32 samples per word with a word clock.
// Optional majority-of-3 tick-rate glitch filter enabled by defining DEGLITCH_EN.
module sig_deser #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PRESCALE    = 1,
    parameter int unsigned WCNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    sig_deser_if.master  bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BCNT_W = 5;
    localparam int unsigned PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX  = PCNT_W'(PRESCALE - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WORD_W - 1);
    localparam logic [BCNT_W-1:0] BCNT_HALF = BCNT_W'(WORD_W / 2);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [PCNT_W-1:0]      pcnt_q, pcnt_d;
    logic [WORD_W-1:0]      sh_q, sh_d;
    logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
    logic [WORD_W-1:0]      dsq_q, dsq_d;
    logic                   pclk_q, pclk_d;
    logic                   wvalid_q, wvalid_d;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    logic                   s, s_f, tick;

`ifdef DEGLITCH_EN
    logic h1_q, h1_d, h2_q, h2_d;
`endif

    // Next-state logic: sampling advances only on a prescaler tick outside hold.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], bus.sig};
        s        = sync_q[SYNC_STAGES-1];
        tick     = (pcnt_q == PCNT_MAX) && !bus.hold;
        pcnt_d   = pcnt_q;
        sh_d     = sh_q;
        bcnt_d   = bcnt_q;
        dsq_d    = dsq_q;
        pclk_d   = pclk_q;
        wvalid_d = 1'b0;
        wcnt_d   = wcnt_q;
`ifdef DEGLITCH_EN
        h1_d = h1_q;
        h2_d = h2_q;
        s_f  = (s & h1_q) | (s & h2_q) | (h1_q & h2_q);
`else
        s_f  = s;
`endif
        if (!bus.hold) begin
            pcnt_d = (pcnt_q == PCNT_MAX) ? '0 : pcnt_q + 1'b1;
        end
        if (tick) begin
            sh_d   = (sh_q >> 1) | (WORD_W'(s_f) << (WORD_W - 1));
            bcnt_d = bcnt_q + 1'b1;
            pclk_d = (bcnt_d < BCNT_HALF);
`ifdef DEGLITCH_EN
            h1_d = s;
            h2_d = h1_q;
`endif
            if (bcnt_q == BCNT_LAST) begin
                dsq_d    = sh_d;
                wvalid_d = 1'b1;
                wcnt_d   = wcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            pcnt_q   <= '0;
            sh_q     <= '0;
            bcnt_q   <= '0;
            dsq_q    <= '0;
            pclk_q   <= 1'b0;
            wvalid_q <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            sync_q   <= sync_d;
            pcnt_q   <= pcnt_d;
            sh_q     <= sh_d;
            bcnt_q   <= bcnt_d;
            dsq_q    <= dsq_d;
            pclk_q   <= pclk_d;
            wvalid_q <= wvalid_d;
            wcnt_q   <= wcnt_d;
        end
    end

`ifdef DEGLITCH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            h1_q <= 1'b0;
            h2_q <= 1'b0;
        end else begin
            h1_q <= h1_d;
            h2_q <= h2_d;
        end
    end
`endif

    assign bus.dsq    = dsq_q;
    assign bus.pclk   = pclk_q;
    assign bus.wvalid = wvalid_q;
    assign bus.wcnt   = wcnt_q;
endmodule

// File: tb/tb_sig_deser.sv
// Bench for sig_deser: two instances (PRESCALE 1 and 4) against a sample-list reference model,
// plus directed vectors and corner-case sequences.
module tb_sig_deser;
    localparam int SYNC = 2;
    localparam int P [2]    = '{1, 4};
    localparam int WMOD [2] = '{65536, 8};
`ifdef DEGLITCH_EN
    localparam logic [31:0] FIRST_ONES = 32'hFFFF_FFF8;
    localparam logic [31:0] HOLD_WORD  = 32'h0000_0007;
`else
    localparam logic [31:0] FIRST_ONES = 32'hFFFF_FFFC;
    localparam logic [31:0] HOLD_WORD  = 32'h0000_0003;
`endif

    logic clk = 1'b0;
    logic rst_r, sig_r, hold_r;
    logic chk_on = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sig_deser_if #(.WCNT_W(16)) bus0 ();
    sig_deser_if #(.WCNT_W(3))  bus1 ();
    assign bus0.sig  = sig_r;
    assign bus0.hold = hold_r;
    assign bus1.sig  = sig_r;
    assign bus1.hold = hold_r;

    sig_deser #(.SYNC_STAGES(2), .PRESCALE(1), .WCNT_W(16)) u0 (.clk(clk), .rst(rst_r), .bus(bus0.master));
    sig_deser #(.SYNC_STAGES(2), .PRESCALE(4), .WCNT_W(3))  u1 (.clk(clk), .rst(rst_r), .bus(bus1.master));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: list of samples taken at every PRESCALE-th non-hold cycle, 32 per word.
    logic [SYNC-1:0] hist;
    int          nh [2], k [2], qn [2], e_wcnt [2];
    logic [31:0] acc [2], e_dsq [2];
    logic        h1m [2], h2m [2], e_wv [2], e_pclk [2];

    always @(posedge clk) begin
        logic s_raw, smp;
        s_raw = hist[SYNC-1];
        smp   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (rst_r) begin
                nh[i] = 0; k[i] = 0; qn[i] = 0; acc[i] = '0; e_dsq[i] = '0;
                e_wcnt[i] = 0; e_wv[i] = 1'b0; e_pclk[i] = 1'b0; h1m[i] = 1'b0; h2m[i] = 1'b0;
            end else begin
                e_wv[i] = 1'b0;
                if (!hold_r) begin
                    if ((nh[i] % P[i]) == P[i] - 1) begin
`ifdef DEGLITCH_EN
                        smp    = ((int'(s_raw) + int'(h1m[i]) + int'(h2m[i])) >= 2);
                        h2m[i] = h1m[i];
                        h1m[i] = s_raw;
`else
                        smp    = s_raw;
`endif
                        acc[i][qn[i]] = smp;
                        qn[i]++;
                        k[i]++;
                        if (qn[i] == 32) begin
                            e_dsq[i]  = acc[i];
                            e_wv[i]   = 1'b1;
                            e_wcnt[i] = (e_wcnt[i] + 1) % WMOD[i];
                            qn[i]     = 0;
                        end
                        e_pclk[i] = ((k[i] % 32) < 16);
                    end
                    nh[i]++;
                end
            end
        end
        hist = rst_r ? '0 : {hist[SYNC-2:0], sig_r};
    end

    // Continuous comparison of both instances against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("m0.dsq",    bus0.dsq,            e_dsq[0]);
            check("m0.pclk",   32'(bus0.pclk),      32'(e_pclk[0]));
            check("m0.wvalid", 32'(bus0.wvalid),    32'(e_wv[0]));
            check("m0.wcnt",   32'(bus0.wcnt),      32'(e_wcnt[0]));
            check("m1.dsq",    bus1.dsq,            e_dsq[1]);
            check("m1.pclk",   32'(bus1.pclk),      32'(e_pclk[1]));
            check("m1.wvalid", 32'(bus1.wvalid),    32'(e_wv[1]));
            check("m1.wcnt",   32'(bus1.wcnt),      32'(e_wcnt[1]));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_r = 1'b1;
        cyc(n);
        rst_r = 1'b0;
    endtask

    // Counts negedges until the selected instance shows wvalid; returns bound on timeout.
    task automatic wait_wv(input int sel, input int bound, output int n);
        logic wv;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            wv = sel ? bus1.wvalid : bus0.wvalid;
        end while (!wv && n < bound);
        if (!wv) n = bound;
    endtask

    typedef struct {
        logic        sig;
        logic        hold;
        int          ncyc;
        logic        wv;
        logic [31:0] dsq;
        int          wcnt;
        logic        pclk;
    } vec_t;

    initial begin
        vec_t        vt [9];
        int          n, nw, pc_hi;
        logic [31:0] words [8];
        int          times [8];
        logic [31:0] orw;

        vt[0] = '{1'b1, 1'b0,  1, 1'b0, 32'h0,        0, 1'b1};
        vt[1] = '{1'b1, 1'b0, 14, 1'b0, 32'h0,        0, 1'b1};
        vt[2] = '{1'b1, 1'b0,  1, 1'b0, 32'h0,        0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 15, 1'b0, 32'h0,        0, 1'b0};
        vt[4] = '{1'b1, 1'b0,  1, 1'b1, FIRST_ONES,   1, 1'b1};
        vt[5] = '{1'b1, 1'b0,  1, 1'b0, FIRST_ONES,   1, 1'b1};
        vt[6] = '{1'b1, 1'b0, 31, 1'b1, 32'hFFFF_FFFF, 2, 1'b1};
        vt[7] = '{1'b1, 1'b1,  5, 1'b0, 32'hFFFF_FFFF, 2, 1'b1};
        vt[8] = '{1'b0, 1'b0, 32, 1'b1, HOLD_WORD,    3, 1'b1};

        // Reset with sig high: outputs held at zero every reset cycle.
        rst_r = 1'b1; sig_r = 1'b1; hold_r = 1'b0;
        @(negedge clk);
        chk_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst.dsq",    bus0.dsq,          32'h0);
            check("rst.pclk",   32'(bus0.pclk),    32'h0);
            check("rst.wvalid", 32'(bus0.wvalid),  32'h0);
            check("rst.wcnt",   32'(bus0.wcnt),    32'h0);
            @(negedge clk);
        end
        rst_r = 1'b0;

        // Directed vectors: constant high, then hold, then low.
        for (int i = 0; i < 9; i++) begin
            sig_r = vt[i].sig; hold_r = vt[i].hold;
            cyc(vt[i].ncyc);
            check($sformatf("vec%0d.wvalid", i), 32'(bus0.wvalid), 32'(vt[i].wv));
            check($sformatf("vec%0d.dsq", i),    bus0.dsq,         vt[i].dsq);
            check($sformatf("vec%0d.wcnt", i),   32'(bus0.wcnt),   32'(vt[i].wcnt));
            check($sformatf("vec%0d.pclk", i),   32'(bus0.pclk),   32'(vt[i].pclk));
        end

        // Toggle every clk: alternating words, identical from the second on, 32 clk apart.
        sig_r = 1'b0; hold_r = 1'b0;
        do_reset(2);
        sig_r = 1'b1;
        nw = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus0.wvalid && nw < 8) begin
                words[nw] = bus0.dsq; times[nw] = c; nw++;
            end
            sig_r = ~sig_r;
        end
        check("toggle.nwords", 32'(nw >= 5), 32'h1);
        for (int w = 1; w < nw; w++) begin
            check("toggle.pattern", 32'(words[w] == 32'h5555_5555 || words[w] == 32'hAAAA_AAAA), 32'h1);
            if (w >= 2) begin
                check("toggle.same",    words[w], words[w-1]);
                check("toggle.spacing", 32'(times[w] - times[w-1]), 32'd32);
            end
        end

        // Prescale 4 with sig low: 128 clk word period, pclk 64 high / 64 low.
        sig_r = 1'b0;
        do_reset(2);
        wait_wv(1, 300, n);
        check("pre.first", 32'(n), 32'd128);
        check("pre.dsq",   bus1.dsq, 32'h0);
        check("pre.wcnt1", 32'(bus1.wcnt), 32'd1);
        n = 0; pc_hi = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus1.pclk) pc_hi++;
        end while (!bus1.wvalid && n < 300);
        check("pre.period", 32'(n), 32'd128);
        check("pre.pclk_hi", 32'(pc_hi), 32'd64);
        check("pre.wcnt2", 32'(bus1.wcnt), 32'd2);

        // Hold 10 clk at bcnt=20 of the second word, then a mid-word reset.
        sig_r = 1'b1;
        do_reset(2);
        cyc(52);
        hold_r = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold.dsq",    bus0.dsq,         FIRST_ONES);
            check("hold.pclk",   32'(bus0.pclk),   32'h0);
            check("hold.wvalid", 32'(bus0.wvalid), 32'h0);
            check("hold.wcnt",   32'(bus0.wcnt),   32'd1);
        end
        hold_r = 1'b0;
        wait_wv(0, 100, n);
        check("hold.resume", 32'(n), 32'd12);
        check("hold.word",   bus0.dsq, 32'hFFFF_FFFF);
        cyc(20);
        do_reset(1);
        check("midrst.dsq",  bus0.dsq,       32'h0);
        check("midrst.wcnt", 32'(bus0.wcnt), 32'h0);
        check("midrst.pclk", 32'(bus0.pclk), 32'h0);
        wait_wv(0, 100, n);
        check("midrst.next", 32'(n), 32'd32);

        // Single 1-clk pulse on a low input.
        sig_r = 1'b0;
        do_reset(2);
        cyc(40);
        sig_r = 1'b1;
        cyc(1);
        sig_r = 1'b0;
        orw = '0; n = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (bus0.wvalid) orw = orw | bus0.dsq;
        end
`ifdef DEGLITCH_EN
        check("glitch.bits", 32'($countones(orw)), 32'd0);
`else
        check("glitch.bits", 32'($countones(orw)), 32'd1);
`endif

        // Random traffic with occasional hold and reset.
        do_reset(2);
        for (int c = 0; c < 3000; c++) begin
            sig_r  = 1'($urandom_range(1, 0));
            hold_r = ($urandom_range(7, 0) == 0);
            rst_r  = ($urandom_range(599, 0) == 0);
            @(negedge clk);
        end
        rst_r = 1'b0; hold_r = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
